core_ctrl: RTL and testbench

CORE_CTRL -- requirements
Module: core_ctrl

---
 rtl/core_ctrl_if.sv | 11 +
 rtl/core_ctrl.sv | 126 ++++++++++++
 tb/tb_core_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/core_ctrl_if.sv
// Memory handshake between the multi-cycle core controller and the memory port.
// The controller issues requests (master); the memory side acknowledges them (slave).
interface core_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_is_fetch;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output mem_is_fetch, input mem_ack);
  modport slave  (input mem_req, input mem_we, input mem_is_fetch, output mem_ack);
endinterface

// File: rtl/core_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/mem/writeback sequencing,
// sticky illegal-opcode trap and a retired-instruction counter.
module core_ctrl (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        opcode,
  input  logic              branch_taken,
  core_ctrl_if.master       bus,
  output logic              ir_we,
  output logic              pc_we,
  output logic [1:0]        pc_sel,
  output logic              rf_we,
  output logic [1:0]        wb_sel,
  output logic              illegal,
  output logic [2:0]        state,
  output logic              retire,
  output logic [31:0]       instret
);

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_TRAP    = 3'd7
  } state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  state_e      state_q, state_d;
  logic [6:0]  opcode_q;
  logic        run_q;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_OP: is_legal = 1'b1;
      default:                          is_legal = 1'b0;
    endcase
  endfunction

  // run_q synchronises reset release: the FSM leaves RESET one edge after rst_n is seen high.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RESET;
      opcode_q <= '0;
      illegal  <= 1'b0;
      instret  <= '0;
      run_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (state_q == S_DECODE) begin
        opcode_q <= opcode;
        if (!is_legal(opcode)) illegal <= 1'b1;
      end
      if (retire) instret <= instret + 32'd1;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:   state_d = run_q ? S_FETCH : S_RESET;
      S_FETCH:   if (bus.mem_ack) state_d = S_DECODE;
      S_DECODE:  state_d = is_legal(opcode) ? S_EXECUTE : S_TRAP;
      S_EXECUTE: state_d = (opcode_q == OP_LOAD || opcode_q == OP_STORE) ? S_MEM : S_WB;
      S_MEM:     if (bus.mem_ack) state_d = (opcode_q == OP_STORE) ? S_FETCH : S_WB;
      S_WB:      state_d = S_FETCH;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_RESET;
    endcase
  end

  always_comb begin
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_is_fetch = 1'b0;
    ir_we            = 1'b0;
    pc_we            = 1'b0;
    pc_sel           = 2'b00;
    rf_we            = 1'b0;
    wb_sel           = 2'b00;
    retire           = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_req      = 1'b1;
        bus.mem_is_fetch = 1'b1;
        ir_we            = bus.mem_ack;
      end
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = (opcode_q == OP_STORE);
        if (bus.mem_ack && opcode_q == OP_STORE) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      S_WB: begin
        pc_we  = 1'b1;
        retire = 1'b1;
        rf_we  = (opcode_q != OP_BRANCH && opcode_q != OP_STORE);
        if (opcode_q == OP_LOAD)                          wb_sel = 2'b01;
        else if (opcode_q == OP_JAL || opcode_q == OP_JALR) wb_sel = 2'b10;
        if (opcode_q == OP_JAL || (opcode_q == OP_BRANCH && branch_taken)) pc_sel = 2'b01;
        else if (opcode_q == OP_JALR)                                      pc_sel = 2'b10;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Directed self-checking bench for core_ctrl: one instruction of each class,
// trap entry/exit, instret wrap and asynchronous reset mid-handshake.
module tb_core_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        ir_we, pc_we, rf_we, illegal, retire;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  state;
  logic [31:0] instret;

  core_ctrl_if bus();

  core_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .bus          (bus),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .illegal      (illegal),
    .state        (state),
    .retire       (retire),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] ADDI   = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BAD    = 7'b1111111;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock; outputs are sampled at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // From FETCH: wait `waits` cycles, ack, present opcode in DECODE and
  // scramble it afterwards so later states must use the latched copy.
  task automatic fetch(input logic [6:0] opc, input int waits);
    check("fetch_state", 32'(state), 32'd1);
    for (int i = 0; i < waits; i++) begin
      bus.mem_ack = 1'b0;
      #1 check("fetch_hold_req", {31'd0, bus.mem_req}, 32'd1);
      step();
    end
    bus.mem_ack = 1'b1;
    #1 check("fetch_ir_we", {31'd0, ir_we}, 32'd1);
    step();
    bus.mem_ack = 1'b0;
    opcode = opc;
    check("decode_state", 32'(state), 32'd2);
    step();
    opcode = 7'b1010101;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; opcode = '0; branch_taken = 1'b0; bus.mem_ack = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_instret", instret, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rel_edge1_state", 32'(state), 32'd0);
    step();
    check("rel_edge2_state", 32'(state), 32'd1);

    // ADDI with ack on the 2nd FETCH cycle: 1,1,2,3,5,1
    check("addi_is_fetch", {31'd0, bus.mem_is_fetch}, 32'd1);
    check("addi_we", {31'd0, bus.mem_we}, 32'd0);
    check("addi_no_ir_we", {31'd0, ir_we}, 32'd0);
    fetch(ADDI, 1);
    check("addi_exec", 32'(state), 32'd3);
    check("addi_exec_retire", {31'd0, retire}, 32'd0);
    step();
    check("addi_wb", 32'(state), 32'd5);
    check("addi_rf_we", {31'd0, rf_we}, 32'd1);
    check("addi_wb_sel", {30'd0, wb_sel}, 32'd0);
    check("addi_retire", {31'd0, retire}, 32'd1);
    check("addi_pc_we", {31'd0, pc_we}, 32'd1);
    step();
    check("addi_back", 32'(state), 32'd1);
    check("addi_instret", instret, 32'd1);
    check("addi_retire_off", {31'd0, retire}, 32'd0);

    // LOAD, immediate acks
    fetch(LOAD, 0);
    step();
    check("ld_mem", 32'(state), 32'd4);
    check("ld_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("ld_mem_fetch", {31'd0, bus.mem_is_fetch}, 32'd0);
    bus.mem_ack = 1'b1;
    #1 check("ld_ack_no_retire", {31'd0, retire}, 32'd0);
    step();
    bus.mem_ack = 1'b0;
    check("ld_wb", 32'(state), 32'd5);
    check("ld_rf_we", {31'd0, rf_we}, 32'd1);
    check("ld_wb_sel", {30'd0, wb_sel}, 32'd1);
    step();
    check("ld_instret", instret, 32'd2);

    // STORE, ack after 3 wait cycles
    fetch(STORE, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      bus.mem_ack = (i == 3);
      #1;
      check("st_req", {31'd0, bus.mem_req}, 32'd1);
      check("st_we", {31'd0, bus.mem_we}, 32'd1);
      check("st_rf_we", {31'd0, rf_we}, 32'd0);
      check("st_retire", {31'd0, retire}, (i == 3) ? 32'd1 : 32'd0);
      check("st_pc_we", {31'd0, pc_we}, (i == 3) ? 32'd1 : 32'd0);
      step();
    end
    bus.mem_ack = 1'b0;
    check("st_back", 32'(state), 32'd1);
    check("st_instret", instret, 32'd3);

    // BRANCH taken / not taken, JALR, JAL (mem_ack in WB ignored)
    for (int k = 0; k < 4; k++) begin
      logic [6:0] op;
      logic [1:0] exp_pc, exp_wb;
      logic       exp_rf;
      op     = (k < 2) ? BRANCH : (k == 2) ? JALR : JAL;
      exp_pc = (k == 0) ? 2'b01 : (k == 1) ? 2'b00 : (k == 2) ? 2'b10 : 2'b01;
      exp_wb = (k < 2) ? 2'b00 : 2'b10;
      exp_rf = (k >= 2);
      fetch(op, 0);
      step();
      branch_taken = (k == 0);
      bus.mem_ack  = (k == 3);
      #1;
      check("ctl_pc_sel", {30'd0, pc_sel}, {30'd0, exp_pc});
      check("ctl_wb_sel", {30'd0, wb_sel}, {30'd0, exp_wb});
      check("ctl_rf_we", {31'd0, rf_we}, {31'd0, exp_rf});
      step();
      bus.mem_ack = 1'b0;
      branch_taken = 1'b0;
      check("ctl_back", 32'(state), 32'd1);
      check("ctl_instret", instret, 32'(4 + k));
    end

    // instret wrap
    force dut.instret = 32'hFFFF_FFFF;
    #1 release dut.instret;
    #1 check("wrap_preload", instret, 32'hFFFF_FFFF);
    fetch(ADDI, 0);
    step();
    step();
    check("wrap_zero", instret, 32'd0);

    // Illegal opcode -> absorbing TRAP
    fetch(BAD, 0);
    check("trap_state", 32'(state), 32'd7);
    check("trap_illegal", {31'd0, illegal}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      bus.mem_ack = 1'b1;
      #1;
      check("trap_hold", 32'(state), 32'd7);
      check("trap_req", {31'd0, bus.mem_req}, 32'd0);
      step();
    end
    bus.mem_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("trap_rst_illegal", {31'd0, illegal}, 32'd0);
    check("trap_rst_state", 32'(state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    check("refetch_state", 32'(state), 32'd1);

    // Asynchronous reset mid-FETCH
    #1 check("midfetch_req", {31'd0, bus.mem_req}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midfetch_rst_req", {31'd0, bus.mem_req}, 32'd0);
    check("midfetch_rst_state", 32'(state), 32'd0);
    check("midfetch_rst_instret", instret, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
